// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem decode/response fabric.
// Holds the FSM state encoding, slot index names and the fixed response words.
// Also provides the address-to-slot decode helper used by the fabric.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int SLOT_GPIO  = 0;
  localparam int SLOT_AUDIO = 1;
  localparam int SLOT_VIDEO = 2;
  localparam int SLOT_SD    = 3;
  localparam int SLOT_I2C   = 4;
  localparam int SLOT_FLASH = 5;

  localparam logic [31:0] RDATA_UNMAPPED = 32'h0000_0000;
  localparam logic [31:0] RDATA_TIMEOUT  = 32'hFFFF_FFFF;

  // True when the top address byte selects the given slot.
  function automatic logic slot_hit(input logic [31:0] addr, input logic [7:0] base_id,
                                    input int slot);
    return addr[31:24] == (base_id + 8'(slot));
  endfunction

endpackage

// File: rtl/iomem_fabric.sv
// Registered decode/response stage between the picosoc iomem master and its peripherals.
// Latency: 3 cycles minimum (capture, slot access, response); unmapped/absent 1 cycle.
// Backpressure: slot ready stalls ACCESS up to TIMEOUT_CYCLES; master drop aborts silently.
module iomem_fabric
  import iomem_pkg::*;
#(
  parameter int                   NUM_SLOTS      = 6,
  parameter logic [7:0]           BASE_ID        = 8'h03,
  parameter logic [NUM_SLOTS-1:0] PRESENT_MASK   = '1,
  parameter int                   TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    m_valid,
  output logic                    m_ready,
  input  logic [3:0]              m_wstrb,
  input  logic [31:0]             m_addr,
  input  logic [31:0]             m_wdata,
  output logic [31:0]             m_rdata,
  output logic [NUM_SLOTS-1:0]    s_valid,
  output logic [3:0]              s_wstrb,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  input  logic [NUM_SLOTS-1:0]    s_ready,
  input  logic [32*NUM_SLOTS-1:0] s_rdata,
  input  logic                    err_clear,
  output logic                    err_timeout,
  output logic                    err_unmapped
);

  localparam int             CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W:0] TO_LIM = TIMEOUT_CYCLES[CNT_W:0];

  state_t               state, state_next;
  logic [NUM_SLOTS-1:0] hit_oh, sel_oh;
  logic                 mapped, present;
  logic                 sel_ready;
  logic [31:0]          sel_rdata;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W:0]       cnt_inc;
  logic                 timeout_hit;
  logic                 capture, load_rdata, set_unm, set_to;
  logic [31:0]          rdata_next;

  // Decode the live master address into a one-hot slot hit vector.
  always_comb begin
    hit_oh = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_oh[i] = slot_hit(m_addr, BASE_ID, i);
    end
  end

  assign mapped  = |hit_oh;
  assign present = |(hit_oh & PRESENT_MASK);

  // Collect ready/rdata from the captured slot only; other slots are ignored.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (sel_oh[i]) sel_rdata = sel_rdata | s_rdata[32*i +: 32];
    end
  end

  assign sel_ready   = |(s_ready & sel_oh);
  assign cnt_inc     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit = cnt_inc >= TO_LIM;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load_rdata = 1'b0;
    rdata_next = RDATA_UNMAPPED;
    set_unm    = 1'b0;
    set_to     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m_valid) begin
          capture = 1'b1;
          if (present) begin
            state_next = ST_ACCESS;
          end else begin
            // Absent slots answer quietly; only truly unmapped addresses flag.
            load_rdata = 1'b1;
            rdata_next = RDATA_UNMAPPED;
            set_unm    = !mapped;
            state_next = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (!m_valid) begin
          state_next = ST_IDLE;
        end else if (sel_ready) begin
          load_rdata = 1'b1;
          rdata_next = sel_rdata;
          state_next = ST_RESP;
        end else if (timeout_hit) begin
          load_rdata = 1'b1;
          rdata_next = RDATA_TIMEOUT;
          set_to     = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture registers, response data and the saturating wait counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      sel_oh  <= '0;
      m_rdata <= '0;
      cnt     <= '0;
    end else begin
      if (capture) begin
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_wstrb <= m_wstrb;
        sel_oh  <= hit_oh;
        cnt     <= '0;
      end else if (state == ST_ACCESS && !cnt_inc[CNT_W]) begin
        cnt <= cnt_inc[CNT_W-1:0];
      end
      if (load_rdata) m_rdata <= rdata_next;
    end
  end

  // Sticky error flags: a set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_timeout  <= 1'b0;
      err_unmapped <= 1'b0;
    end else begin
      err_timeout  <= set_to  | (err_timeout  & ~err_clear);
      err_unmapped <= set_unm | (err_unmapped & ~err_clear);
    end
  end

  assign m_ready = (state == ST_RESP);
  assign s_valid = (state == ST_ACCESS) ? sel_oh : '0;

endmodule

// File: tb/tb_iomem_fabric.sv
// Directed bench for iomem_fabric: decode, latency, timeout, errors, abort and reset.
// Main instance uses an 8-cycle timeout; a second instance has slot 0 absent.
// Expected values are hand-computed constants.
module tb_iomem_fabric;

  logic         clk = 1'b0;
  logic         resetn;
  logic         m_valid, abs_valid;
  logic [3:0]   m_wstrb;
  logic [31:0]  m_addr, m_wdata;
  logic [5:0]   s_ready;
  logic [191:0] s_rdata;
  logic         err_clear;

  logic         m_ready, abs_ready;
  logic [31:0]  m_rdata, abs_rdata;
  logic [5:0]   s_valid, abs_s_valid;
  logic [3:0]   s_wstrb, abs_s_wstrb;
  logic [31:0]  s_addr, s_wdata, abs_s_addr, abs_s_wdata;
  logic         err_timeout, err_unmapped, abs_err_to, abs_err_unm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iomem_fabric #(.TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_ready(m_ready),
    .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .err_clear(err_clear),
    .err_timeout(err_timeout), .err_unmapped(err_unmapped)
  );

  iomem_fabric #(.PRESENT_MASK(6'b111110), .TIMEOUT_CYCLES(8)) u_abs (
    .clk(clk), .resetn(resetn), .m_valid(abs_valid), .m_ready(abs_ready),
    .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(abs_rdata),
    .s_valid(abs_s_valid), .s_wstrb(abs_s_wstrb), .s_addr(abs_s_addr), .s_wdata(abs_s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .err_clear(err_clear),
    .err_timeout(abs_err_to), .err_unmapped(abs_err_unm)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Run one master access on the main instance. Slot 'slot' asserts ready
  // 'wait_n' cycles after s_valid first appears (wait_n < 0: never).
  // lat = cycle m_ready seen (40 = no response within budget).
  task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input int slot, input int wait_n, input logic [31:0] rd,
                           input logic [5:0] noise, output int lat, output logic [5:0] sv_seen,
                           output logic [31:0] wd_seen, output logic [3:0] ws_seen);
    m_addr  = a;
    m_wdata = wd;
    m_wstrb = ws;
    s_ready = noise;
    m_valid = 1'b1;
    lat     = 0;
    sv_seen = '0;
    wd_seen = '0;
    ws_seen = '0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (m_ready) break;
      sv_seen = sv_seen | s_valid;
      if (s_valid != 6'd0) begin
        wd_seen = s_wdata;
        ws_seen = s_wstrb;
      end
      if (slot >= 0 && wait_n >= 0 && lat == 1 + wait_n) begin
        s_ready[slot] = 1'b1;
        s_rdata[slot*32 +: 32] = rd;
      end
    end
    m_valid = 1'b0;
    s_ready = '0;
  endtask

  // One more cycle after a response: m_ready must already be gone.
  task automatic after_resp(input string tag);
    @(posedge clk); #1;
    chk(tag, {31'd0, m_ready}, 32'd0);
  endtask

  int          lat;
  logic [5:0]  sv;
  logic [31:0] wd;
  logic [3:0]  ws;
  logic        seen;

  initial begin
    resetn    = 1'b0;
    m_valid   = 1'b0;
    abs_valid = 1'b0;
    m_wstrb   = '0;
    m_addr    = '0;
    m_wdata   = '0;
    s_ready   = '0;
    s_rdata   = '0;
    err_clear = 1'b0;
    #12;
    chk("rst_m_ready", {31'd0, m_ready}, 32'd0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_s_valid", {26'd0, s_valid}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_errs", {30'd0, err_timeout, err_unmapped}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Slot 0 read, ready 2 cycles after s_valid, other slots' ready held high.
    do_access(32'h0300_0004, 32'h0, 4'h0, 0, 2, 32'h1234_5678, 6'b111110, lat, sv, wd, ws);
    chk("rd0_lat", lat, 32'd4);
    chk("rd0_rdata", m_rdata, 32'h1234_5678);
    chk("rd0_onehot", {26'd0, sv}, 32'h0000_0001);
    after_resp("rd0_ready_width");
    chk("rd0_rdata_hold", m_rdata, 32'h1234_5678);

    // Write to slot 4, ready one cycle after s_valid.
    do_access(32'h0700_0000, 32'hA5A5_A5A5, 4'hF, 4, 1, 32'h0, 6'b0, lat, sv, wd, ws);
    chk("wr4_lat", lat, 32'd3);
    chk("wr4_onehot", {26'd0, sv}, 32'h0000_0010);
    chk("wr4_wdata", wd, 32'hA5A5_A5A5);
    chk("wr4_wstrb", {28'd0, ws}, 32'h0000_000F);
    after_resp("wr4_ready_width");

    // Unmapped address.
    do_access(32'h1000_0000, 32'h0, 4'h0, -1, -1, 32'h0, 6'b0, lat, sv, wd, ws);
    chk("unm_lat", lat, 32'd1);
    chk("unm_rdata", m_rdata, 32'd0);
    chk("unm_flag", {31'd0, err_unmapped}, 32'd1);
    chk("unm_no_svalid", {26'd0, sv}, 32'd0);
    after_resp("unm_ready_width");
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    chk("unm_clear", {31'd0, err_unmapped}, 32'd0);

    // Slot 2 never ready: timeout after 8 ACCESS cycles.
    do_access(32'h0500_0000, 32'h0, 4'h0, -1, -1, 32'h0, 6'b0, lat, sv, wd, ws);
    chk("to_lat", lat, 32'd9);
    chk("to_rdata", m_rdata, 32'hFFFF_FFFF);
    chk("to_flag", {31'd0, err_timeout}, 32'd1);
    chk("to_onehot", {26'd0, sv}, 32'h0000_0004);
    after_resp("to_ready_width");
    err_clear = 1'b1;
    @(posedge clk); #1;
    chk("to_clear", {31'd0, err_timeout}, 32'd0);

    // Timeout with err_clear held high throughout: the set must win.
    do_access(32'h0500_0000, 32'h0, 4'h0, -1, -1, 32'h0, 6'b0, lat, sv, wd, ws);
    err_clear = 1'b0;
    chk("to_clr_lat", lat, 32'd9);
    chk("to_set_wins", {31'd0, err_timeout}, 32'd1);
    after_resp("to_clr_ready_width");

    // Master abort during ACCESS on slot 3.
    m_addr  = 32'h0600_0000;
    m_valid = 1'b1;
    @(posedge clk); #1;
    chk("abt_svalid", {26'd0, s_valid}, 32'h0000_0008);
    @(posedge clk); #1;
    m_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen = seen | m_ready;
      if (i == 0) chk("abt_svalid_drop", {26'd0, s_valid}, 32'd0);
    end
    chk("abt_no_resp", {31'd0, seen}, 32'd0);
    chk("abt_no_err", {30'd0, err_timeout, err_unmapped}, 32'h2);
    chk("abt_rdata_hold", m_rdata, 32'hFFFF_FFFF);

    // Absent-slot instance: first a normal read on slot 1, then slot 0.
    m_addr             = 32'h0400_0000;
    s_ready            = 6'b000010;
    s_rdata[63:32]     = 32'hDEAD_BEEF;
    abs_valid          = 1'b1;
    @(posedge clk); #1;
    chk("abs_rd1_svalid", {26'd0, abs_s_valid}, 32'h0000_0002);
    @(posedge clk); #1;
    abs_valid = 1'b0;
    s_ready   = '0;
    chk("abs_rd1_ready", {31'd0, abs_ready}, 32'd1);
    chk("abs_rd1_rdata", abs_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    m_addr    = 32'h0300_0000;
    abs_valid = 1'b1;
    @(posedge clk); #1;
    abs_valid = 1'b0;
    chk("abs_ready_c1", {31'd0, abs_ready}, 32'd1);
    chk("abs_rdata", abs_rdata, 32'd0);
    chk("abs_no_svalid", {26'd0, abs_s_valid}, 32'd0);
    chk("abs_no_err", {30'd0, abs_err_to, abs_err_unm}, 32'd0);

    // Reset asserted mid-ACCESS on slot 1.
    @(posedge clk); #1;
    m_addr  = 32'h0400_0010;
    m_wdata = 32'h5555_AAAA;
    m_wstrb = 4'h3;
    m_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstm_pre_svalid", {26'd0, s_valid}, 32'h0000_0002);
    resetn = 1'b0;
    #1;
    chk("rstm_svalid", {26'd0, s_valid}, 32'd0);
    chk("rstm_m_ready", {31'd0, m_ready}, 32'd0);
    chk("rstm_m_rdata", m_rdata, 32'd0);
    chk("rstm_s_addr", s_addr, 32'd0);
    chk("rstm_s_wdata", s_wdata, 32'd0);
    chk("rstm_s_wstrb", {28'd0, s_wstrb}, 32'd0);
    chk("rstm_errs", {30'd0, err_timeout, err_unmapped}, 32'd0);
    m_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | m_ready | (s_valid != 6'd0);
    end
    chk("rstm_stay_idle", {31'd0, seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iomem_fabric.md
# iomem_fabric

Registered decode and response stage between the picosoc `iomem_*` master port and the memory-mapped peripherals (GPIO, audio, video, SD card, I2C, flash). It replaces the ad-hoc combinational ready/rdata muxing in the top level. Each access is captured, a one-hot per-slot valid is driven, the selected slot's ready/rdata is collected, and a single-cycle registered ready is returned to the CPU. Unmapped or absent slots get a defined zero response, and stuck slots are cut off by a timeout. Both events are recorded in sticky error flags.

## Interface
Parameters:
- `NUM_SLOTS`, default 6. Slot i decodes `addr[31:24] == BASE_ID + i`.
- `BASE_ID`, default 8'h03. Slot 0 is GPIO at 0x03; slot 5 is flash at 0x08.
- `PRESENT_MASK`, default 6'b111111. When bit i = 0, slot i is absent and is answered internally.
- `TIMEOUT_CYCLES`, default 255. Maximum number of ACCESS cycles before a forced response. Legal range is 1..65535.

Ports:
- `clk`, input, 1: system clock.
- `resetn`, input, 1: reset, asynchronous, active-low.
- `m_valid`, input, 1: master request.
- `m_ready`, output, 1: master response strobe, one cycle wide.
- `m_wstrb`, input, 4: byte write strobes; 0 means read.
- `m_addr`, input, 32: master address.
- `m_wdata`, input, 32: master write data.
- `m_rdata`, output, 32: registered read data, valid while `m_ready` = 1.
- `s_valid`, output, NUM_SLOTS: one-hot slot request.
- `s_wstrb`, output, 4: captured strobes, shared by all slots.
- `s_addr`, output, 32: captured address, shared by all slots.
- `s_wdata`, output, 32: captured write data, shared by all slots.
- `s_ready`, input, NUM_SLOTS: slot ready lines.
- `s_rdata`, input, 32*NUM_SLOTS: flattened slot read data; slot i occupies bits [32i+31:32i].
- `err_clear`, input, 1: clears both sticky flags.
- `err_timeout`, output, 1: sticky flag, set when a timeout occurs.
- `err_unmapped`, output, 1: sticky flag, set when an unmapped address is accessed.

## Operation
- **State machine:** IDLE, ACCESS, RESP.
- **IDLE:**
  - On `m_valid` = 1, capture addr, wdata and wstrb, and decode the slot.
  - Mapped and present slot: go to ACCESS.
  - Unmapped address or absent slot: load `m_rdata` = 0, go to RESP.
  - An unmapped address also sets `err_unmapped`. An absent slot does not.
- **ACCESS:**
  - `s_valid[sel]` = 1; all other `s_valid` bits are 0.
  - On `s_ready[sel]` = 1: register the slot's rdata into `m_rdata`, drop `s_valid` on the next cycle, go to RESP.
  - The timeout counter increments every ACCESS cycle. When it reaches TIMEOUT_CYCLES without ready: `m_rdata` = 32'hFFFF_FFFF, set `err_timeout`, go to RESP.
  - `s_ready` bits of non-selected slots are ignored.
- **RESP:** `m_ready` = 1 for exactly one cycle, then go to IDLE. `m_rdata` holds its value until the next capture.
- **Master abort:** if `m_valid` falls while in ACCESS, return to IDLE next cycle. `s_valid` drops, no response is issued, and no error is set.
- **Error flags:**
  - A set event and `err_clear` in the same cycle: set wins.
  - Flags are only ever cleared by `err_clear` or by reset.
- **Counter width:** `$clog2(TIMEOUT_CYCLES+1)`. The counter clears on every entry to ACCESS and saturates; it never wraps.
- **Writes:** returning slot rdata on a write is harmless; the master ignores it.

## Timing
- Reset values: state = IDLE; `m_ready` = 0; `m_rdata` = 0; `s_valid` = 0; `s_addr`, `s_wdata`, `s_wstrb` = 0; both error flags = 0; counter = 0.
- Present slot with combinational ready: `m_valid` sampled at cycle 0, `s_valid` high at cycle 1 (ready sampled in cycle 1), `m_ready` at cycle 2. This is the 3-cycle minimum latency.
- Every slot wait cycle adds one cycle of latency.
- Unmapped or absent slot: `m_ready` at cycle 1.
- Timeout: `m_ready` at cycle TIMEOUT_CYCLES+1.
- There is no back-to-back acceptance. IDLE re-samples `m_valid` starting one cycle after RESP. The picosoc deasserts valid in that cycle, so no duplicate capture occurs.
- Slots must tolerate `s_valid` dropping the cycle after they assert ready.

## Structure
- Package `iomem_pkg`:
  - State enum.
  - `SLOT_GPIO`..`SLOT_FLASH` index constants.
  - Response constants: `RDATA_UNMAPPED` = 0, `RDATA_TIMEOUT` = 32'hFFFF_FFFF.
  - Slot-decode function.
- Single module with no sub-modules. The timeout counter is inline.

## Test plan
- Read slot 0 (addr 0x0300_0004), with `s_ready[0]` asserted 2 cycles after `s_valid` and `s_rdata[0]` = 0x1234_5678 → `m_ready` at cycle 4, `m_rdata` = 0x1234_5678, `s_valid` one-hot = 6'b000001.
- Write to addr 0x0700_0000 with wstrb 4'hF and wdata 0xA5A5_A5A5 → `s_valid[4]` high, `s_wdata` = 0xA5A5_A5A5, `m_ready` one cycle after `s_ready[4]`.
- Access addr 0x1000_0000 → `m_ready` at cycle 1, `m_rdata` = 0, `err_unmapped` = 1. `err_clear` pulsed alone → `err_unmapped` = 0.
- TIMEOUT_CYCLES = 8, slot 2 never ready → `m_ready` at cycle 9, `m_rdata` = 0xFFFF_FFFF, `err_timeout` = 1. Timeout event coincident with `err_clear` → flag stays 1.
- PRESENT_MASK = 6'b111110, access addr 0x0300_0000 → `m_ready` at cycle 1, `m_rdata` = 0, no `s_valid` asserted, no error flag set.
- `resetn` low during ACCESS → all outputs return to reset values immediately. With `m_valid` = 0 after release, the state stays IDLE.
